digit_serial_adder: RTL and testbench
=====================================

Name: digit_serial_adder

Overview:
- Parametrised, multi-cycle successor to the single-bit combinational full adder.
- Adds two WIDTH-bit operands DIGIT bits per clock, using one DIGIT-wide adder slice and a registered carry.
- Targets area-constrained modular additions in the hashing datapath, e.g. 32-bit SHA-256 word adds.
- Operands enter and results leave through valid/ready handshakes.

Parameters:
- WIDTH, 32, operand and sum width in bits.
- DIGIT, 4, bits added per cycle. WIDTH % DIGIT must be 0, otherwise elaboration fails with $error. DIGIT=1 gives a pure bit-serial adder.
- NDIG (localparam), WIDTH/DIGIT, number of RUN cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands a, b, cin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  sum and cout are valid
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset: one clock is clk; reset rst_n is synchronous and active-low. On a clk edge with rst_n=0:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
  - Internal digit counter, carry register and operand shift registers are cleared.
- Reset mid-operation aborts the operation. No result is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b into shift registers, carry register=cin, counter=0, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle: {c, s} = a_sh[DIGIT-1:0] + b_sh[DIGIT-1:0] + carry.
  - s is shifted into the sum register from the MSB side, so digits land LSB-first in the correct positions.
  - a_sh and b_sh shift right by DIGIT. carry=c. counter++.
  - When counter==NDIG-1, that cycle's digit is the last one; go to DONE with cout=c.
- DONE:
  - out_valid=1. sum and cout are stable.
  - Hold until out_valid&&out_ready, then go to IDLE on that edge.
  - in_ready stays 0 in DONE. There is no accept-while-output overlap.
- Latency:
  - Operands are accepted at edge T0.
  - out_valid is high from edge T0+NDIG.
  - If out_ready is held high, the earliest next accept is at edge T0+NDIG+2.
  - Throughput is one operation per NDIG+2 cycles.
- sum and cout keep their last result after leaving DONE until the next RUN overwrites them. Only out_valid qualifies them.
- Wrap-around: the result is modulo 2^WIDTH. Overflow appears only on cout; no saturation.
- in_valid while not in IDLE is ignored. Operands need only be valid in the accept cycle.
- Changing a, b or cin during RUN has no effect.
- out_ready while not in DONE is ignored.
- DIGIT==WIDTH: NDIG=1, a single RUN cycle, latency 1.

Optional Feature:
- Macro: DIGIT_SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands at accept.
  - sub=1: the b shift register captures ~b and the carry register captures 1. cin is ignored. sum=(a-b) mod 2^WIDTH; cout=1 means no borrow (a>=b).
  - sub=0: behaviour is identical to the undefined case.
- Undefined: no sub port; addition only. Logic is otherwise identical.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release -> in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
- Basic add, WIDTH=32, DIGIT=4: a=0x0000_0001, b=0x0000_0002, cin=0 accepted at T0 -> out_valid at T0+8, sum=0x0000_0003, cout=0.
- Full carry ripple across all digits: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1. Also a=0xFFFF_FFFF, b=0xFFFF_FFFF, cin=1 -> sum=0xFFFF_FFFF, cout=1.
- Backpressure and ignored input:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout stable and in_ready=0.
  - in_valid pulses during RUN/DONE are not accepted.
  - Raising out_ready -> IDLE next edge, in_ready=1.
- Reset mid-RUN: accept a=0x1234_5678, b=0x1111_1111, assert rst_n=0 at T0+3 -> all outputs at reset values, no out_valid. The next op a=5, b=7 -> sum=12.
- DIGIT=1 and DIGIT=32 builds: a=0x8000_0000, b=0x8000_0000 -> sum=0, cout=1, with out_valid at T0+32 and T0+1 respectively.
- With DIGIT_SERIAL_ADDER_SUB_EN: a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0. a=7, b=5, sub=1 -> sum=2, cout=1.

Source files
------------

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per clock behind valid/ready handshakes.
// Optional subtract mode is enabled by defining DIGIT_SERIAL_ADDER_SUB_EN (adds the sub input).
module digit_serial_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_bad_digit
        $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;

    logic             sub_op;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic [DIGIT:0]   digit_sum;
    logic [WIDTH-1:0] sum_shift;
    logic             last_digit;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    assign sub_op = sub;
`else
    assign sub_op = 1'b0;
`endif

    // Subtraction is a + ~b + 1, so only the loaded b and initial carry differ.
    assign b_load     = sub_op ? ~b : b;
    assign c_load     = sub_op ? 1'b1 : cin;
    assign last_digit = (cnt == CW'(NDIG - 1));

    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        digit_sum = '0;
        digit_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    end

    // New digits enter at the MSB end; after NDIG shifts the first digit sits at bit 0.
    if (DIGIT == WIDTH) begin : g_single_digit
        assign sum_shift = digit_sum[DIGIT-1:0];
    end else begin : g_multi_digit
        assign sum_shift = {digit_sum[DIGIT-1:0], sum[WIDTH-1:DIGIT]};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b_load;
                        carry    <= c_load;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    sum   <= sum_shift;
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    carry <= digit_sum[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (last_digit) begin
                        cout      <= digit_sum[DIGIT];
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: DIGIT=4, DIGIT=1 and DIGIT=32 instances driven in lock-step
// and checked against an arithmetic reference model, including latency and handshake behaviour.
module tb_digit_serial_adder;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         cin = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    logic         sub = 1'b0;
`endif

    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [2:0]   busy;
    logic [2:0]   cout;
    logic [W-1:0] sum_q [3];

    int ndig [3] = '{8, 32, 1};
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .a(a), .b(b), .cin(cin),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid[0]), .out_ready(out_ready), .sum(sum_q[0]),
        .cout(cout[0]), .busy(busy[0])
    );

    digit_serial_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .a(a), .b(b), .cin(cin),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid[1]), .out_ready(out_ready), .sum(sum_q[1]),
        .cout(cout[1]), .busy(busy[1])
    );

    digit_serial_adder #(.WIDTH(W), .DIGIT(32)) u_d32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .a(a), .b(b), .cin(cin),
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid[2]), .out_ready(out_ready), .sum(sum_q[2]),
        .cout(cout[2]), .busy(busy[2])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands, result is {cout, sum}.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
        logic [W:0] r;
        if (s) begin
            r[W-1:0] = x - y;
            r[W]     = (x >= y);
        end else begin
            r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        end
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'h7);
        check({tag, "_out_valid"}, 64'(out_valid), 64'h0);
        check({tag, "_busy"}, 64'(busy), 64'h0);
        check({tag, "_cout"}, 64'(cout), 64'h0);
        for (int i = 0; i < 3; i++) check({tag, "_sum"}, 64'(sum_q[i]), 64'h0);
    endtask

    // Called on a negedge with all instances idle; returns on a negedge with all idle again.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic s);
        logic [W:0] exp;
        logic [2:0] seen;
        exp = model(x, y, ci, s);
        check("accept_in_ready", 64'(in_ready), 64'h7);
        a = x;
        b = y;
        cin = ci;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        sub = s;
`endif
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        cin = ~ci;
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        sub = ~s;
`endif
        check("run_busy", 64'(busy), 64'h7);
        check("run_in_ready", 64'(in_ready), 64'h0);
        seen = '0;
        for (int k = 0; k <= 40; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (!seen[i] && out_valid[i]) begin
                    seen[i] = 1'b1;
                    check($sformatf("latency_d%0d", i), 64'(k), 64'(ndig[i]));
                    check($sformatf("sum_d%0d", i), 64'(sum_q[i]), 64'(exp[W-1:0]));
                    check($sformatf("cout_d%0d", i), 64'(cout[i]), 64'(exp[W]));
                end
            end
            if (seen == 3'b111) break;
            @(negedge clk);
        end
        if (seen != 3'b111) check("out_valid_timeout", 64'(seen), 64'h7);
        @(negedge clk);
    endtask

    initial begin
        logic [W:0] exp;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
        run_op(32'd5, 32'd7, 1'b0, 1'b1);
        run_op(32'd7, 32'd5, 1'b1, 1'b1);
`endif

        // Backpressure with in_valid held high throughout RUN and DONE.
        out_ready = 1'b0;
        exp = model(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0);
        a = 32'hDEAD_BEEF;
        b = 32'h0123_4567;
        cin = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            cin = $urandom_range(0, 1);
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 64'(out_valid), 64'h7);
            check("bp_in_ready", 64'(in_ready), 64'h0);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("bp_sum_d%0d", i), 64'(sum_q[i]), 64'(exp[W-1:0]));
                check($sformatf("bp_cout_d%0d", i), 64'(cout[i]), 64'(exp[W]));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", 64'(out_valid), 64'h0);
        check("release_in_ready", 64'(in_ready), 64'h7);
        check("release_busy", 64'(busy), 64'h0);
        check("retained_sum", 64'(sum_q[0]), 64'(exp[W-1:0]));
        check("retained_cout", 64'(cout[0]), 64'(exp[W]));

        // Reset three edges after accept aborts the operation.
        a = 32'h1234_5678;
        b = 32'h1111_1111;
        cin = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrun_reset");
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_reset_out_valid", 64'(out_valid), 64'h0);
        end
        run_op(32'd5, 32'd7, 1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            ra = $urandom;
            rb = (n % 5 == 0) ? ~ra : 32'($urandom);
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'b0);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
